// File: rtl/decoder_if.sv
// rtl/decoder_if.sv - digit/control inputs and registered segment outputs of the seven-segment decoder
interface decoder_if;
    logic [3:0] bcd;
    logic       lamp_test;
    logic       blank;
    logic [6:0] sete_seg;
    logic       invalid;

    modport master (
        output bcd,
        output lamp_test,
        output blank,
        input  sete_seg,
        input  invalid
    );

    modport slave (
        input  bcd,
        input  lamp_test,
        input  blank,
        output sete_seg,
        output invalid
    );
endinterface

// File: rtl/decoder.sv
// rtl/decoder.sv - registered BCD/hex to seven-segment decoder; DECODER_HEX_EN enables glyphs for 10-15
module decoder #(
    parameter int COMMON_ANODE = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    decoder_if.slave dec
);
    // XOR mask applied at the output register; invalid is never masked
    localparam logic [6:0] POLARITY = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0] ALL_LIT  = 7'h7F;
    localparam logic [6:0] ALL_DARK = 7'h00;

    logic [6:0] decode_pat;
    logic       decode_invalid;
    logic [6:0] seg_q;
    logic       invalid_q;

    always_comb begin
        decode_pat     = 7'h01;
        decode_invalid = 1'b0;
        unique case (dec.bcd)
            4'd0:    decode_pat = 7'h7E;
            4'd1:    decode_pat = 7'h30;
            4'd2:    decode_pat = 7'h6D;
            4'd3:    decode_pat = 7'h79;
            4'd4:    decode_pat = 7'h33;
            4'd5:    decode_pat = 7'h5B;
            4'd6:    decode_pat = 7'h5F;
            4'd7:    decode_pat = 7'h70;
            4'd8:    decode_pat = 7'h7F;
            4'd9:    decode_pat = 7'h7B;
`ifdef DECODER_HEX_EN
            4'd10:   decode_pat = 7'h77;
            4'd11:   decode_pat = 7'h1F;
            4'd12:   decode_pat = 7'h4E;
            4'd13:   decode_pat = 7'h3D;
            4'd14:   decode_pat = 7'h4F;
            4'd15:   decode_pat = 7'h47;
`else
            // Non-decimal codes show a dash on segment g and raise invalid
            default: begin
                decode_pat     = 7'h01;
                decode_invalid = 1'b1;
            end
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q     <= ALL_DARK ^ POLARITY;
            invalid_q <= 1'b0;
        end else if (dec.lamp_test) begin
            seg_q     <= ALL_LIT ^ POLARITY;
            invalid_q <= 1'b0;
        end else if (dec.blank) begin
            seg_q     <= ALL_DARK ^ POLARITY;
            invalid_q <= 1'b0;
        end else begin
            seg_q     <= decode_pat ^ POLARITY;
            invalid_q <= decode_invalid;
        end
    end

    assign dec.sete_seg = seg_q;
    assign dec.invalid  = invalid_q;
endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - self-checking bench for decoder, common-cathode and common-anode instances side by side
module tb_decoder;
    logic       clk;
    logic       rst_n;
    logic [3:0] bcd;
    logic       lamp_test;
    logic       blank;

    int checks;
    int errors;

    decoder_if if_cc ();
    decoder_if if_ca ();

    assign if_cc.bcd       = bcd;
    assign if_cc.lamp_test = lamp_test;
    assign if_cc.blank     = blank;
    assign if_ca.bcd       = bcd;
    assign if_ca.lamp_test = lamp_test;
    assign if_ca.blank     = blank;

    decoder #(.COMMON_ANODE(0)) dut_cc (.clk(clk), .rst_n(rst_n), .dec(if_cc.slave));
    decoder #(.COMMON_ANODE(1)) dut_ca (.clk(clk), .rst_n(rst_n), .dec(if_ca.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyph table, active-high, indexed by digit value
    logic [6:0] glyph [0:15];
    logic [6:0] exp_seg;
    logic       exp_inv;

    initial begin
        glyph[0] = 7'h7E; glyph[1] = 7'h30; glyph[2] = 7'h6D; glyph[3] = 7'h79;
        glyph[4] = 7'h33; glyph[5] = 7'h5B; glyph[6] = 7'h5F; glyph[7] = 7'h70;
        glyph[8] = 7'h7F; glyph[9] = 7'h7B;
`ifdef DECODER_HEX_EN
        glyph[10] = 7'h77; glyph[11] = 7'h1F; glyph[12] = 7'h4E;
        glyph[13] = 7'h3D; glyph[14] = 7'h4F; glyph[15] = 7'h47;
`else
        for (int i = 10; i < 16; i++) glyph[i] = 7'h01;
`endif
    end

    task automatic model(input logic r, input logic lt, input logic bk, input logic [3:0] b);
        if (!r) begin
            exp_seg = 7'h00; exp_inv = 1'b0;
        end else if (lt) begin
            exp_seg = 7'h7F; exp_inv = 1'b0;
        end else if (bk) begin
            exp_seg = 7'h00; exp_inv = 1'b0;
        end else begin
            exp_seg = glyph[b];
`ifdef DECODER_HEX_EN
            exp_inv = 1'b0;
`else
            exp_inv = (b > 4'd9);
`endif
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cc_seg"}, {1'b0, if_cc.sete_seg}, {1'b0, exp_seg});
        check({tag, ".cc_inv"}, {7'b0, if_cc.invalid},  {7'b0, exp_inv});
        check({tag, ".ca_seg"}, {1'b0, if_ca.sete_seg}, {1'b0, ~exp_seg});
        check({tag, ".ca_inv"}, {7'b0, if_ca.invalid},  {7'b0, exp_inv});
    endtask

    // Drive inputs mid-cycle, clock them in, then compare just after the edge
    task automatic apply(input logic r, input logic lt, input logic bk, input logic [3:0] b, input string tag);
        @(negedge clk);
        rst_n = r; lamp_test = lt; blank = bk; bcd = b;
        @(posedge clk);
        #1;
        model(r, lt, bk, b);
        check_all(tag);
    endtask

    initial begin
        logic [3:0] digits [0:6];
        checks = 0;
        errors = 0;
        rst_n = 1'b0; lamp_test = 1'b0; blank = 1'b0; bcd = 4'd0;

        apply(1'b0, 1'b0, 1'b0, 4'd1, "reset0");
        apply(1'b0, 1'b1, 1'b1, 4'd1, "reset_over_lamp");

        digits[0] = 4'd1; digits[1] = 4'd2; digits[2] = 4'd4; digits[3] = 4'd8;
        digits[4] = 4'd9; digits[5] = 4'd6; digits[6] = 4'd5;
        for (int i = 0; i < 7; i++) apply(1'b1, 1'b0, 1'b0, digits[i], $sformatf("digit%0d", digits[i]));

        apply(1'b1, 1'b0, 1'b0, 4'd10, "code10");
        apply(1'b1, 1'b0, 1'b0, 4'd3,  "after10");
        apply(1'b1, 1'b0, 1'b0, 4'd15, "code15");
        apply(1'b1, 1'b0, 1'b0, 4'd0,  "zero");

        apply(1'b1, 1'b0, 1'b1, 4'd0, "blank");
        apply(1'b1, 1'b1, 1'b1, 4'd0, "lamp_over_blank");
        apply(1'b1, 1'b1, 1'b0, 4'd12, "lamp_over_invalid");
        apply(1'b1, 1'b0, 1'b0, 4'd0, "release");
        apply(1'b1, 1'b0, 1'b0, 4'd0, "hold");

        // Reset asserted between edges must not disturb the outputs until the next edge
        apply(1'b1, 1'b0, 1'b0, 4'd8, "pre_reset8");
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_all("reset_between_edges");
        @(posedge clk);
        #1;
        model(1'b0, 1'b0, 1'b0, 4'd8);
        check_all("reset_taken");
        apply(1'b1, 1'b0, 1'b0, 4'd7, "first_after_reset");

        for (int n = 0; n < 300; n++) begin
            logic r, lt, bk;
            r  = ($urandom_range(15) != 0);
            lt = ($urandom_range(7) == 0);
            bk = ($urandom_range(5) == 0);
            apply(r, lt, bk, 4'($urandom_range(15)), $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
